// File: rtl/serial_adder.sv
// Digit-serial add/sub: WIDTH/DIGIT cycles per op, result held in DONE until out_ready (back-pressure stalls intake).
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [DIGIT:0]         slice_full;
  logic [DIGIT-1:0]       slice_s;
  logic                   c_d;
  logic [WIDTH+DIGIT-1:0] psum_cat;
  logic [WIDTH-1:0]       psum_d;
  logic                   last_step;

  // One DIGIT-bit full-adder slice, reused every RUN cycle.
  assign slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  assign slice_s    = slice_full[DIGIT-1:0];
  assign c_d        = slice_full[DIGIT];
  assign psum_cat   = {slice_s, psum_q};
  assign psum_d     = psum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step  = (cnt_q == CW'(STEPS - 1));

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;
  logic c_msb;
  logic ovf_d;
  // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign c_msb    = slice_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign ovf_d    = c_msb ^ c_d;
  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      psum_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + 1, with borrow-in folded into the initial carry.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= carry_in ^ sub;
            psum_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          psum_q <= psum_d;
          c_q    <= c_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            sum_q       <= psum_d;
            carry_q     <= c_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance, 8-bit.
module tb_serial_adder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid1, in_valid4;
  logic       carry_in, sub, out_ready;
  logic [7:0] a, b;

  logic       rdy1, vld1, c1, busy1;
  logic [7:0] sum1;
  logic       rdy4, vld4, c4, busy4;
  logic [7:0] sum4;

  bit         sel;
  logic       m_rdy, m_vld, m_c, m_busy;
  logic [7:0] m_sum;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf1, ovf4, m_ovf;
  assign m_ovf = sel ? ovf4 : ovf1;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy1),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(vld1), .out_ready(out_ready), .sum(sum1), .carry(c1), .busy(busy1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(rdy4),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(vld4), .out_ready(out_ready), .sum(sum4), .carry(c4), .busy(busy4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf4)
`endif
  );

  assign m_rdy  = sel ? rdy4  : rdy1;
  assign m_vld  = sel ? vld4  : vld1;
  assign m_c    = sel ? c4    : c1;
  assign m_busy = sel ? busy4 : busy1;
  assign m_sum  = sel ? sum4  : sum1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge where out_valid is seen.
  task automatic do_op(input bit s, input logic [7:0] ta, input logic [7:0] tb_v,
                       input bit tsub, input bit tcin, input logic [7:0] es,
                       input bit ec, input bit eo, input int elat, input string tag);
    int n;
    sel = s;
    #1;
    check({tag, "_rdy"}, m_rdy, 1);
    a = ta; b = tb_v; sub = tsub; carry_in = tcin;
    if (s) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    a = 8'h00; b = 8'h00; sub = ~tsub; carry_in = ~tcin;
    check({tag, "_busy"}, m_busy, 1);
    n = 0;
    while (!m_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_sum"}, m_sum, es);
    check({tag, "_carry"}, m_c, ec);
    check({tag, "_rdy_done"}, m_rdy, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, m_ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0;
    a = 8'h00; b = 8'h00; sub = 1'b0; carry_in = 1'b0; out_ready = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy1", rdy1, 0);
    check("rst_rdy4", rdy4, 0);
    check("rst_vld", vld1, 0);
    check("rst_busy", busy1, 0);
    check("rst_sum", sum1, 0);
    check("rst_carry", c1, 0);
    rst = 1'b0;

    do_op(0, 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1, 8, "add1"); @(negedge clk);
    do_op(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 8, "add2"); @(negedge clk);
    do_op(0, 8'hFF, 8'h01, 0, 1, 8'h01, 1, 0, 8, "add3"); @(negedge clk);
    do_op(0, 8'h10, 8'h20, 1, 0, 8'hF0, 0, 0, 8, "sub1"); @(negedge clk);
    do_op(0, 8'h20, 8'h10, 1, 1, 8'h0F, 1, 0, 8, "sub2"); @(negedge clk);

    // Back-pressure: result held while out_ready low, new operands ignored.
    out_ready = 1'b0;
    do_op(0, 8'h33, 8'h44, 0, 0, 8'h77, 0, 0, 8, "bp");
    for (int i = 0; i < 5; i++) begin
      a = 8'hAA; b = 8'h55; in_valid1 = 1'b1;
      @(negedge clk);
      check("bp_vld", vld1, 1);
      check("bp_sum", sum1, 8'h77);
      check("bp_carry", c1, 0);
      check("bp_rdy", rdy1, 0);
      check("bp_busy", busy1, 0);
    end
    in_valid1 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_vld", vld1, 0);
    do_op(0, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 8, "after_bp"); @(negedge clk);

    // Reset at step 3 of an in-flight op.
    sel = 1'b0;
    a = 8'h0F; b = 8'h0F; sub = 1'b0; carry_in = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", rdy1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_vld", vld1, 0);
    check("mid_busy0", busy1, 0);
    check("mid_sum", sum1, 0);
    check("mid_carry", c1, 0);
    check("mid_rdy", rdy1, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("mid_ovf", ovf1, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_no_result", vld1, 0);
    end
    do_op(0, 8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 8, "post_rst"); @(negedge clk);

    // Four bits per cycle: two-cycle latency.
    do_op(1, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 2, "d4_add1"); @(negedge clk);
    do_op(1, 8'hA5, 8'h5A, 0, 1, 8'h00, 1, 0, 2, "d4_add2"); @(negedge clk);
    do_op(1, 8'h20, 8'h30, 1, 0, 8'hF0, 0, 0, 2, "d4_sub"); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
